// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM target for the nlp16af memory phases.
// One request at a time over req/ack, programmable wait states per direction,
// out-of-range accesses complete with err=1 and no side effects.
module mem_responder #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int WAIT_RD    = 1,
   parameter int WAIT_WR    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t      state;
   logic [3:0]  cnt;
   req_t        lat;

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   logic                  sel_we;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [DEPTH_LOG2-1:0] idx;
   logic [3:0]            load;
   logic                  in_range;
   logic                  to_resp;
   logic                  wr_fire;

   // Request seen at the edge entering RESP: live inputs when a zero-wait
   // request is accepted straight from IDLE, otherwise the latched copy.
   always_comb begin
      load      = we ? 4'(WAIT_WR) : 4'(WAIT_RD);
      sel_we    = lat.we;
      sel_addr  = lat.addr;
      sel_wdata = lat.wdata;
      if (state == IDLE) begin
         sel_we    = we;
         sel_addr  = addr;
         sel_wdata = wdata;
      end
      idx      = sel_addr[DEPTH_LOG2-1:0];
      in_range = (sel_addr >> DEPTH_LOG2) == '0;
      to_resp  = (state == IDLE && req && load == 4'd0) ||
                 (state == WAIT && cnt == 4'd1);
      // rst_n gate keeps an aborted or held-in-reset request from committing
      wr_fire  = rst_n && to_resp && sel_we && in_range;
   end

   // RAM write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_fire) mem[idx] <= sel_wdata;
   end

   // Control FSM with registered ack/err/rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         lat   <= '0;
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (req) begin
               lat.we    <= we;
               lat.addr  <= addr;
               lat.wdata <= wdata;
               cnt       <= load;
               state     <= (load == 4'd0) ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (to_resp) begin
            ack <= 1'b1;
            err <= !in_range;
            if (!sel_we) rdata <= in_range ? mem[idx] : '1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench; the driver pushes the expected response
// (ack cycle, err, rdata) and per-DUT monitors pop and compare on each ack.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, ack, err;
   logic [15:0] addr, wdata, rdata;
   logic        req3, we3, ack3, err3;
   logic [15:0] addr3, wdata3, rdata3;

   typedef struct {
      int          cyc;
      logic        err;
      logic [15:0] rd;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] last_rd[2];
   int          cyc = 0;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_RD(1), .WAIT_WR(0)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .err(err));

   mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_RD(1), .WAIT_WR(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
      .ack(ack3), .rdata(rdata3), .err(err3));

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor for the default-wait DUT
   always @(negedge clk) begin
      if (ack) begin
         if (q0.size() == 0) chk("unexpected_ack0", 32'(ack), 32'd0);
         else begin
            exp_t e;
            e = q0.pop_front();
            chk("ack0_cycle", 32'(cyc), 32'(e.cyc));
            chk("err0", 32'(err), 32'(e.err));
            chk("rdata0", 32'(rdata), 32'(e.rd));
         end
      end
   end

   // Monitor for the WAIT_WR=3 DUT
   always @(negedge clk) begin
      if (ack3) begin
         if (q1.size() == 0) chk("unexpected_ack3", 32'(ack3), 32'd0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("ack3_cycle", 32'(cyc), 32'(e.cyc));
            chk("err3", 32'(err3), 32'(e.err));
            chk("rdata3", 32'(rdata3), 32'(e.rd));
         end
      end
   end

   // Wait (bounded) for the selected DUT's ack
   task automatic wait_ack(input int d);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = (d == 0) ? ack : ack3;
      end
      if (!seen) chk("ack_timeout", 32'(seen), 32'd1);
   endtask

   // Called at posedge+1; v is wdata for writes, expected rdata for reads
   task automatic issue(input int d, input logic w, input logic [15:0] a,
                        input logic [15:0] v, input logic e_err, input bit keep);
      exp_t e;
      int   wt;
      wt = w ? ((d == 1) ? 3 : 0) : 1;
      if (!w) last_rd[d] = v;
      e.cyc = cyc + 1 + wt;
      e.err = e_err;
      e.rd  = last_rd[d];
      if (d == 0) begin
         req = 1'b1; we = w; addr = a; wdata = v;
         q0.push_back(e);
      end else begin
         req3 = 1'b1; we3 = w; addr3 = a; wdata3 = v;
         q1.push_back(e);
      end
      wait_ack(d);
      @(posedge clk); #1;
      if (!keep) begin
         if (d == 0) req = 1'b0; else req3 = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      req = 0; we = 0; addr = '0; wdata = '0;
      req3 = 0; we3 = 0; addr3 = '0; wdata3 = '0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset mid-write on the WAIT_WR=3 instance
      issue(1, 1, 16'h0010, 16'h5A5A, 0, 0);
      issue(1, 0, 16'h0010, 16'h5A5A, 0, 0);
      req3 = 1'b1; we3 = 1'b1; addr3 = 16'h0010; wdata3 = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ack", 32'(ack3), 32'd0);
      chk("abort_rdata", 32'(rdata3), 32'd0);
      last_rd[0] = '0; last_rd[1] = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1, 0, 16'h0010, 16'h5A5A, 0, 0);

      // Basic write then read
      issue(0, 1, 16'h0005, 16'hBEEF, 0, 0);
      issue(0, 0, 16'h0005, 16'hBEEF, 0, 0);

      // Out-of-range: no aliasing onto word 0
      issue(0, 1, 16'h0000, 16'h0F0F, 0, 0);
      issue(0, 1, 16'h0400, 16'hCAFE, 1, 0);
      issue(0, 0, 16'h0400, 16'hFFFF, 1, 0);
      issue(0, 0, 16'h0000, 16'h0F0F, 0, 0);

      // Back-to-back with req held across ack
      issue(0, 1, 16'h0001, 16'h00AA, 0, 1);
      issue(0, 0, 16'h0001, 16'h00AA, 0, 0);

      // Inputs changed during WAIT are ignored
      issue(0, 1, 16'h0002, 16'h2222, 0, 0);
      issue(0, 1, 16'h0003, 16'h3333, 0, 0);
      req = 1'b1; we = 1'b0; addr = 16'h0002;
      last_rd[0] = 16'h2222;
      e.cyc = cyc + 2; e.err = 1'b0; e.rd = 16'h2222;
      q0.push_back(e);
      @(posedge clk); #1;
      addr = 16'h0003; we = 1'b1; wdata = 16'hDEAD;
      wait_ack(0);
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      issue(0, 0, 16'h0003, 16'h3333, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("idle_err", 32'(err), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
